// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Conditions the raw board pushbuttons and slide switches for use in the
// clk domain. Every input is synchronized, debounced and turned into a
// clean level. The keys also get press/release pulses and an auto-repeat
// pulse train paced by the VGA frame strobe.
//
// Ports
//   clk           system clock, all state updates on its rising edge
//   reset         synchronous active-high reset
//   key_n[3:0]    raw pushbuttons, active-low, asynchronous
//   sw[9:0]       raw slide switches, active-high, asynchronous
//   startOfFrame  one-cycle frame strobe
//   key_level     debounced key state, 1 = pressed
//   key_press     one-cycle pulse on a debounced key press
//   key_release   one-cycle pulse on a debounced key release
//   key_repeat    key_press OR auto-repeat pulse
//   sw_level      debounced switch state
//
// Auto-repeat FSM (one per key)
//   state     | meaning
//   RELEASED  | key up, no repeat activity
//   HOLD_WAIT | key held, counting frames up to REPEAT_DELAY
//   REPEATING | key held, pulsing every REPEAT_PERIOD frames
// -----------------------------------------------------------------------------
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 20,
    parameter int unsigned REPEAT_PERIOD   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic [9:0] sw,
    input  logic       startOfFrame,
    output logic [3:0] key_level,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [3:0] key_repeat,
    output logic [9:0] sw_level
);

    localparam int unsigned NKEY = 4;
    localparam int unsigned NSW  = 10;
    localparam int unsigned NIN  = NKEY + NSW;
    localparam int unsigned CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CW-1:0] DB_TC     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]    DELAY_TC  = 6'(REPEAT_DELAY);
    localparam logic [5:0]    PERIOD_TC = 6'(REPEAT_PERIOD);

    // Key synchronizer flops reset to the raw released level (high), so the
    // inverted view starts at 0 and reset never looks like a key press.
    localparam logic [NIN-1:0] SYNC_RST = {{NSW{1'b0}}, {NKEY{1'b1}}};

    typedef enum logic [1:0] {
        RELEASED,
        HOLD_WAIT,
        REPEATING
    } rpt_state_e;

    // ------------------------------------------------------------------
    // Two-flop synchronizers; bit order is {sw, key_n}
    // ------------------------------------------------------------------
    logic [NIN-1:0] sync1_q;
    logic [NIN-1:0] sync2_q;
    logic [NIN-1:0] in_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
        end else begin
            sync1_q <= {sw, key_n};
            sync2_q <= sync1_q;
        end
    end

    assign in_sync = {sync2_q[NIN-1:NKEY], ~sync2_q[NKEY-1:0]};

    // ------------------------------------------------------------------
    // Debounce: count consecutive mismatch cycles, accept the new value on
    // the cycle the count would pass DEBOUNCE_CYCLES-1.
    // ------------------------------------------------------------------
    logic [CW-1:0]  db_cnt_q [NIN];
    logic [CW-1:0]  db_cnt_d [NIN];
    logic [NIN-1:0] level_q;
    logic [NIN-1:0] level_d;

    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NIN; i++) begin
            db_cnt_d[i] = '0;
            if (in_sync[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_TC) begin
                    level_d[i]  = in_sync[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
            for (int i = 0; i < NIN; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            for (int i = 0; i < NIN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Press / release edge pulses, one cycle after the level changes
    // ------------------------------------------------------------------
    logic [NKEY-1:0] key_prev_q;
    logic [NKEY-1:0] press_q;
    logic [NKEY-1:0] release_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev_q <= '0;
            press_q    <= '0;
            release_q  <= '0;
        end else begin
            key_prev_q <= level_q[NKEY-1:0];
            press_q    <= level_q[NKEY-1:0] & ~key_prev_q;
            release_q  <= ~level_q[NKEY-1:0] & key_prev_q;
        end
    end

    // ------------------------------------------------------------------
    // Auto-repeat FSMs. They act on the registered press/release pulses, so
    // a frame strobe in the press cycle is seen while still RELEASED and is
    // not counted; release is tested first so it beats a due strobe.
    // ------------------------------------------------------------------
    rpt_state_e      rpt_state_q [NKEY];
    logic [5:0]      frame_cnt_q [NKEY];
    logic [NKEY-1:0] rpt_pulse_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_pulse_q <= '0;
            for (int k = 0; k < NKEY; k++) begin
                rpt_state_q[k] <= RELEASED;
                frame_cnt_q[k] <= '0;
            end
        end else begin
            rpt_pulse_q <= '0;
            for (int k = 0; k < NKEY; k++) begin
                unique case (rpt_state_q[k])
                    RELEASED: begin
                        if (press_q[k]) begin
                            rpt_state_q[k] <= HOLD_WAIT;
                            frame_cnt_q[k] <= '0;
                        end
                    end
                    HOLD_WAIT: begin
                        if (release_q[k]) begin
                            rpt_state_q[k] <= RELEASED;
                            frame_cnt_q[k] <= '0;
                        end else if (startOfFrame) begin
                            if (frame_cnt_q[k] + 6'd1 == DELAY_TC) begin
                                rpt_pulse_q[k] <= 1'b1;
                                frame_cnt_q[k] <= '0;
                                rpt_state_q[k] <= REPEATING;
                            end else begin
                                frame_cnt_q[k] <= frame_cnt_q[k] + 6'd1;
                            end
                        end
                    end
                    REPEATING: begin
                        if (release_q[k]) begin
                            rpt_state_q[k] <= RELEASED;
                            frame_cnt_q[k] <= '0;
                        end else if (startOfFrame) begin
                            if (frame_cnt_q[k] + 6'd1 == PERIOD_TC) begin
                                rpt_pulse_q[k] <= 1'b1;
                                frame_cnt_q[k] <= '0;
                            end else begin
                                frame_cnt_q[k] <= frame_cnt_q[k] + 6'd1;
                            end
                        end
                    end
                    default: begin
                        rpt_state_q[k] <= RELEASED;
                        frame_cnt_q[k] <= '0;
                    end
                endcase
            end
        end
    end

    assign key_level   = level_q[NKEY-1:0];
    assign sw_level    = level_q[NIN-1:NKEY];
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_repeat  = press_q | rpt_pulse_q;

endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
//
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=3,
// REPEAT_PERIOD=2. A table of level vectors covers debounce and glitch
// rejection; hand-written sequences cover press/repeat/release timing,
// release racing a due strobe, and reset in the middle of a hold.
// -----------------------------------------------------------------------------
module tb_key_conditioner;

    logic       clk;
    logic       reset;
    logic [3:0] key_n;
    logic [9:0] sw;
    logic       startOfFrame;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] key_repeat;
    logic [9:0] sw_level;

    int n_checks = 0;
    int n_fail   = 0;

    key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (3),
        .REPEAT_PERIOD  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_n),
        .sw          (sw),
        .startOfFrame(startOfFrame),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat),
        .sw_level    (sw_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] key_n;
        logic [9:0] sw;
        int         hold;
        logic [3:0] exp_kl;
        logic [9:0] exp_sl;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " press"},   32'(key_press),   32'h0);
        chk({tag, " release"}, 32'(key_release), 32'h0);
        chk({tag, " repeat"},  32'(key_repeat),  32'h0);
    endtask

    // One key pressed from step 1 up to rel_step-1, strobe when k%10==sof_ph.
    task automatic run_seq(input int key, input int rel_step, input int sof_ph,
                           input int nsteps, input logic [127:0] rep_mask,
                           input int press_at, input int rel_at);
        logic [3:0] bitk;
        bitk = 4'b0001 << key;
        for (int k = 1; k <= nsteps; k++) begin
            key_n        = (k < rel_step) ? ~bitk : 4'hF;
            startOfFrame = ((k % 10) == sof_ph);
            step();
            chk($sformatf("level key%0d step%0d", key, k), 32'(key_level),
                (k >= 6 && k < rel_step + 5) ? 32'(bitk) : 32'h0);
            chk($sformatf("press key%0d step%0d", key, k), 32'(key_press),
                (k == press_at) ? 32'(bitk) : 32'h0);
            chk($sformatf("release key%0d step%0d", key, k), 32'(key_release),
                (k == rel_at) ? 32'(bitk) : 32'h0);
            chk($sformatf("repeat key%0d step%0d", key, k), 32'(key_repeat),
                rep_mask[k] ? 32'(bitk) : 32'h0);
        end
        startOfFrame = 1'b0;
        key_n        = 4'hF;
    endtask

    initial begin
        logic [127:0] m;

        vecs[0]  = '{4'hF,    10'h000, 8, 4'h0, 10'h000};
        vecs[1]  = '{4'b1011, 10'h000, 5, 4'h0, 10'h000};
        vecs[2]  = '{4'b1011, 10'h000, 1, 4'h4, 10'h000};
        vecs[3]  = '{4'b1011, 10'h3FF, 6, 4'h4, 10'h3FF};
        vecs[4]  = '{4'hF,    10'h155, 5, 4'h4, 10'h3FF};
        vecs[5]  = '{4'hF,    10'h155, 1, 4'h0, 10'h155};
        vecs[6]  = '{4'b1101, 10'h155, 3, 4'h0, 10'h155};
        vecs[7]  = '{4'hF,    10'h155, 6, 4'h0, 10'h155};
        vecs[8]  = '{4'hF,    10'h200, 6, 4'h0, 10'h200};
        vecs[9]  = '{4'hF,    10'h000, 3, 4'h0, 10'h200};
        vecs[10] = '{4'h0,    10'h1FF, 9, 4'hF, 10'h1FF};
        vecs[11] = '{4'hF,    10'h000, 6, 4'h0, 10'h000};

        reset        = 1'b1;
        key_n        = 4'hF;
        sw           = 10'h000;
        startOfFrame = 1'b0;
        repeat (3) step();
        chk("reset key_level", 32'(key_level), 32'h0);
        chk("reset sw_level",  32'(sw_level),  32'h0);
        chk_quiet("reset");
        reset = 1'b0;
        step();
        chk_quiet("post-reset");
        repeat (10) step();

        // Level table: debounce latency, boundaries and glitch rejection
        for (int i = 0; i < 12; i++) begin
            key_n = vecs[i].key_n;
            sw    = vecs[i].sw;
            repeat (vecs[i].hold) step();
            chk($sformatf("vec%0d key_level", i), 32'(key_level), 32'(vecs[i].exp_kl));
            chk($sformatf("vec%0d sw_level", i),  32'(sw_level),  32'(vecs[i].exp_sl));
        end
        repeat (10) step();

        // key2: level after 6 edges, press+repeat one cycle later, no strobes
        m = '0; m[7] = 1'b1;
        run_seq(2, 20, 99, 35, m, 7, 26);

        // key0 held 100 cycles, strobe every 10: press, 3rd strobe, every 2nd
        m = '0; m[7] = 1'b1; m[30] = 1'b1; m[50] = 1'b1; m[70] = 1'b1; m[90] = 1'b1;
        run_seq(0, 101, 0, 115, m, 7, 107);

        // strobe in the key_press cycle is not counted
        m = '0; m[7] = 1'b1; m[38] = 1'b1; m[58] = 1'b1;
        run_seq(0, 61, 8, 75, m, 7, 67);

        // key1 release pulse lands on the strobe where a repeat is due
        m = '0; m[7] = 1'b1; m[30] = 1'b1;
        run_seq(1, 43, 0, 85, m, 7, 49);
        repeat (5) step();

        // key3 and sw9 held through a one-cycle reset
        key_n = 4'b0111;
        sw    = 10'h200;
        for (int k = 1; k <= 25; k++) begin
            startOfFrame = ((k % 10) == 0);
            step();
            chk($sformatf("pre-reset press step%0d", k), 32'(key_press),
                (k == 7) ? 32'h8 : 32'h0);
        end
        chk("pre-reset key_level", 32'(key_level), 32'h8);
        chk("pre-reset sw_level",  32'(sw_level),  32'h200);
        reset        = 1'b1;
        startOfFrame = 1'b1;
        step();
        chk("in-reset key_level", 32'(key_level), 32'h0);
        chk("in-reset sw_level",  32'(sw_level),  32'h0);
        chk_quiet("in-reset");
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            startOfFrame = ((k % 10) == 0);
            step();
            chk($sformatf("rst key_level step%0d", k), 32'(key_level),
                (k >= 6) ? 32'h8 : 32'h0);
            chk($sformatf("rst sw_level step%0d", k), 32'(sw_level),
                (k >= 6) ? 32'h200 : 32'h0);
            chk($sformatf("rst press step%0d", k), 32'(key_press),
                (k == 7) ? 32'h8 : 32'h0);
            chk($sformatf("rst repeat step%0d", k), 32'(key_repeat),
                (k == 7 || k == 30) ? 32'h8 : 32'h0);
            chk($sformatf("rst release step%0d", k), 32'(key_release), 32'h0);
        end
        startOfFrame = 1'b0;
        key_n        = 4'hF;
        sw           = 10'h000;
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
